// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared encodings for the RV64 core: datapath width, register
//                count, load/store funct3 codes, major opcodes, ALUOp codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    // Load width codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store width codes (funct3)
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp codes from main decoder to ALU control
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Per-register pending-write counters. Counts up on issue of a
//                register-writing instruction, down on write-back retirement,
//                and reports source-operand hazards and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int NREG   = 32,
    parameter int PCNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_iss_valid,
    input  logic                    i_iss_regwrite,
    input  logic [$clog2(NREG)-1:0] i_iss_rd,
    input  logic                    i_ret_valid,
    input  logic [$clog2(NREG)-1:0] i_ret_rd,
    input  logic [$clog2(NREG)-1:0] i_rs1,
    input  logic [$clog2(NREG)-1:0] i_rs2,
    output logic                    o_sb_full,
    output logic                    o_hz_stall
);

    localparam int                c_rw      = $clog2(NREG);
    localparam logic [PCNT_W-1:0] c_cnt_max = '1;
    localparam logic [PCNT_W-1:0] c_cnt_one = PCNT_W'(1);

    logic [PCNT_W-1:0] r_cnt [NREG];
    logic              w_inc;
    logic [PCNT_W-1:0] w_cnt1;
    logic [PCNT_W-1:0] w_cnt2;
    logic              w_stall1;
    logic              w_stall2;

    // A saturated counter blocks further issue to that rd; x0 never saturates
    assign o_sb_full = i_iss_valid & i_iss_regwrite & (r_cnt[i_iss_rd] == c_cnt_max);
    assign w_inc     = i_iss_valid & i_iss_regwrite & (i_iss_rd != '0) & ~o_sb_full;

    // Counter update; simultaneous issue and retire on one register cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_inc && (i_iss_rd == c_rw'(i)) &&
                    !(i_ret_valid && (i_ret_rd == c_rw'(i)) && (r_cnt[i] != '0))) begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end else if (!(w_inc && (i_iss_rd == c_rw'(i))) &&
                             i_ret_valid && (i_ret_rd == c_rw'(i)) && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - c_cnt_one;
                end
            end
        end
    end

    // A source stalls unless at most one write is pending and it is retiring now
    // (the retiring value is then available on the bypass path)
    always_comb begin
        w_cnt1   = r_cnt[i_rs1];
        w_cnt2   = r_cnt[i_rs2];
        w_stall1 = (i_rs1 != '0) &&
                   ((w_cnt1 > c_cnt_one) ||
                    ((w_cnt1 == c_cnt_one) && !(i_ret_valid && (i_ret_rd == i_rs1))));
        w_stall2 = (i_rs2 != '0) &&
                   ((w_cnt2 > c_cnt_one) ||
                    ((w_cnt2 == c_cnt_one) && !(i_ret_valid && (i_ret_rd == i_rs2))));
        o_hz_stall = w_stall1 | w_stall2;
    end

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/rf_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_unit
//  Description : MEM/WB pipeline register, load-data extraction and
//                sign/zero extension, register-file write port drive, WB
//                bypass onto read ports and pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_unit
    import riscv_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int XLEN   = 64,
    parameter int PCNT_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic                    mem_regwrite,
    input  logic                    mem_memtoreg,
    input  logic [$clog2(NREG)-1:0] mem_rd,
    input  logic [2:0]              mem_funct3,
    input  logic [2:0]              mem_addr_lo,
    input  logic [XLEN-1:0]         mem_alu_result,
    input  logic [XLEN-1:0]         mem_load_data,
    input  logic                    iss_valid,
    input  logic                    iss_regwrite,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    input  logic [$clog2(NREG)-1:0] hz_rs1,
    input  logic [$clog2(NREG)-1:0] hz_rs2,
    input  logic [XLEN-1:0]         rf_readdata1,
    input  logic [XLEN-1:0]         rf_readdata2,
    output logic                    rf_regwrite,
    output logic [$clog2(NREG)-1:0] rf_writereg,
    output logic [XLEN-1:0]         rf_writedata,
    output logic [XLEN-1:0]         byp_data1,
    output logic [XLEN-1:0]         byp_data2,
    output logic                    hz_stall,
    output logic                    sb_full,
    output logic                    ld_err
);

    localparam int c_rw = $clog2(NREG);

    logic              r_wb_valid;
    logic              r_wb_regwrite;
    logic              r_wb_memtoreg;
    logic [c_rw-1:0]   r_wb_rd;
    logic [2:0]        r_wb_funct3;
    logic [2:0]        r_wb_addr_lo;
    logic [XLEN-1:0]   r_wb_alu;
    logic [XLEN-1:0]   r_wb_load;

    logic [31:0]       w_word;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_ld_ext;
    logic              w_ld_bad;
    logic              w_unused_addr_bit0;

    // MEM/WB register: captured every cycle, bubbles arrive as mem_valid=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memtoreg <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_funct3   <= '0;
            r_wb_addr_lo  <= '0;
            r_wb_alu      <= '0;
            r_wb_load     <= '0;
        end else begin
            r_wb_valid    <= mem_valid;
            r_wb_regwrite <= mem_regwrite;
            r_wb_memtoreg <= mem_memtoreg;
            r_wb_rd       <= mem_rd;
            r_wb_funct3   <= mem_funct3;
            r_wb_addr_lo  <= mem_addr_lo;
            r_wb_alu      <= mem_alu_result;
            r_wb_load     <= mem_load_data;
        end
    end

    // Byte offset bit 0 is below the narrowest supported access
    assign w_unused_addr_bit0 = r_wb_addr_lo[0];

    // Load extraction: pick word/halfword by offset, then extend by funct3
    always_comb begin
        w_word   = r_wb_addr_lo[2] ? r_wb_load[32 +: 32] : r_wb_load[0 +: 32];
        w_half   = r_wb_load[16*r_wb_addr_lo[2:1] +: 16];
        w_ld_ext = '0;
        w_ld_bad = 1'b0;
        case (r_wb_funct3)
            F3_LD:   w_ld_ext = r_wb_load;
            F3_LW:   w_ld_ext = {{(XLEN-32){w_word[31]}}, w_word};
            F3_LWU:  w_ld_ext = {{(XLEN-32){1'b0}}, w_word};
            F3_LH:   w_ld_ext = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  w_ld_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_bad = 1'b1;
        endcase
    end

    assign rf_regwrite  = r_wb_valid & r_wb_regwrite & (r_wb_rd != '0);
    assign rf_writereg  = r_wb_rd;
    assign rf_writedata = r_wb_memtoreg ? w_ld_ext : r_wb_alu;
    assign ld_err       = r_wb_valid & r_wb_memtoreg & w_ld_bad;

    // Forward the retiring value; rf_regwrite already excludes x0
    assign byp_data1 = (rf_regwrite && (r_wb_rd == hz_rs1)) ? rf_writedata : rf_readdata1;
    assign byp_data2 = (rf_regwrite && (r_wb_rd == hz_rs2)) ? rf_writedata : rf_readdata2;

    wb_scoreboard #(
        .NREG   (NREG),
        .PCNT_W (PCNT_W)
    ) u_sb (
        .clk            (clk),
        .rst            (rst),
        .i_iss_valid    (iss_valid),
        .i_iss_regwrite (iss_regwrite),
        .i_iss_rd       (iss_rd),
        .i_ret_valid    (rf_regwrite),
        .i_ret_rd       (r_wb_rd),
        .i_rs1          (hz_rs1),
        .i_rs2          (hz_rs2),
        .o_sb_full      (sb_full),
        .o_hz_stall     (hz_stall)
    );

endmodule : rf_writeback_unit
`default_nettype wire

// File: tb/tb_rf_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_writeback_unit
//  Description : Directed self-checking bench for rf_writeback_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3, mem_addr_lo;
    logic [63:0] mem_alu_result, mem_load_data;
    logic        iss_valid, iss_regwrite;
    logic [4:0]  iss_rd, hz_rs1, hz_rs2;
    logic [63:0] rf_readdata1, rf_readdata2;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg;
    logic [63:0] rf_writedata, byp_data1, byp_data2;
    logic        hz_stall, sb_full, ld_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] c_ld_pat = 64'h8000_0001_7FFF_FFFF;

    always #5 clk = ~clk;

    rf_writeback_unit #(.NREG(32), .XLEN(64), .PCNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .iss_valid(iss_valid), .iss_regwrite(iss_regwrite), .iss_rd(iss_rd),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
        .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2),
        .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg), .rf_writedata(rf_writedata),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .hz_stall(hz_stall), .sb_full(sb_full), .ld_err(ld_err)
    );

    task automatic idle();
        mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0; mem_rd = 0;
        mem_funct3 = 0; mem_addr_lo = 0; mem_alu_result = 0; mem_load_data = 0;
        iss_valid = 0; iss_regwrite = 0; iss_rd = 0;
    endtask

    task automatic push_mem(input logic [4:0] rd, input logic m2r, input logic [2:0] f3,
                            input logic [2:0] alo, input logic [63:0] alu, input logic [63:0] ld);
        mem_valid = 1; mem_regwrite = 1; mem_memtoreg = m2r; mem_rd = rd;
        mem_funct3 = f3; mem_addr_lo = alo; mem_alu_result = alu; mem_load_data = ld;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        hz_rs1 = 0; hz_rs2 = 0; rf_readdata1 = 0; rf_readdata2 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        // build state: a WB entry to rd9 and a pending issue to rd9
        push_mem(5'd9, 1'b0, 3'b000, 3'd0, 64'h55, 64'h0);
        iss_valid = 1; iss_regwrite = 1; iss_rd = 5'd9; hz_rs1 = 5'd9;
        @(posedge clk); #1;
        checks++; if (rf_regwrite !== 1'b1) begin errors++; $display("FAIL pre_reset_regwrite: got %b exp 1", rf_regwrite); end
        #2 rst = 1;
        #1;
        checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b exp 0", rf_regwrite); end
        checks++; if (rf_writereg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %0d exp 0", rf_writereg); end
        checks++; if (rf_writedata !== 64'd0) begin errors++; $display("FAIL reset_writedata: got %h exp 0", rf_writedata); end
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL reset_ld_err: got %b exp 0", ld_err); end
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL reset_sb_full: got %b exp 0", sb_full); end
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL reset_hz_stall: got %b exp 0", hz_stall); end
        @(negedge clk);
        rst = 0; idle();
        #1;
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL reset_counter_rd9: hz_stall got %b exp 0", hz_stall); end
    endtask

    task automatic test_load_extend();
        logic [63:0] exp_v [5];
        logic [2:0]  f3_v  [5];
        logic [2:0]  alo_v [5];
        exp_v[0] = 64'hFFFF_FFFF_8000_0001; f3_v[0] = 3'b010; alo_v[0] = 3'd4; // LW
        exp_v[1] = 64'h0000_0000_8000_0001; f3_v[1] = 3'b110; alo_v[1] = 3'd4; // LWU
        exp_v[2] = 64'hFFFF_FFFF_FFFF_8000; f3_v[2] = 3'b001; alo_v[2] = 3'd6; // LH
        exp_v[3] = 64'h0000_0000_0000_8000; f3_v[3] = 3'b101; alo_v[3] = 3'd7; // LHU, bit0 ignored
        exp_v[4] = 64'h8000_0001_7FFF_FFFF; f3_v[4] = 3'b011; alo_v[4] = 3'd3; // LD, offset ignored
        hz_rs2 = 5'd5; rf_readdata2 = 64'h2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_mem(5'd5, 1'b1, f3_v[i], alo_v[i], 64'hBAD, c_ld_pat);
            @(negedge clk);
            idle(); #1;
            checks++; if (rf_writedata !== exp_v[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h exp %h", i, rf_writedata, exp_v[i]); end
            checks++; if (byp_data2 !== exp_v[i]) begin errors++; $display("FAIL load_byp2[%0d]: got %h exp %h", i, byp_data2, exp_v[i]); end
            checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL load_noerr[%0d]: got %b exp 0", i, ld_err); end
        end
        checks++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd5) begin errors++; $display("FAIL load_wport: got we=%b rd=%0d exp we=1 rd=5", rf_regwrite, rf_writereg); end
    endtask

    task automatic test_bypass_stall();
        @(negedge clk);
        iss_valid = 1; iss_regwrite = 1; iss_rd = 5'd7;
        hz_rs1 = 5'd7; hz_rs2 = 5'd0; rf_readdata1 = 64'hAAAA;
        #1;
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL byp_stall_before_issue: got %b exp 0", hz_stall); end
        @(negedge clk);
        iss_valid = 0;
        push_mem(5'd7, 1'b0, 3'b000, 3'd0, 64'h1234, 64'h0);
        #1;
        checks++; if (hz_stall !== 1'b1) begin errors++; $display("FAIL byp_stall_pending: got %b exp 1", hz_stall); end
        @(negedge clk);
        idle(); #1;
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL byp_stall_wb: got %b exp 0", hz_stall); end
        checks++; if (byp_data1 !== 64'h1234) begin errors++; $display("FAIL byp_data1_wb: got %h exp 1234", byp_data1); end
        checks++; if (rf_regwrite !== 1'b1 || rf_writereg !== 5'd7) begin errors++; $display("FAIL byp_wport: got we=%b rd=%0d exp we=1 rd=7", rf_regwrite, rf_writereg); end
        @(negedge clk);
        #1;
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL byp_counter_cleared: got %b exp 0", hz_stall); end
        checks++; if (byp_data1 !== 64'hAAAA) begin errors++; $display("FAIL byp_data1_after: got %h exp aaaa", byp_data1); end
    endtask

    task automatic test_scoreboard_full();
        hz_rs1 = 5'd0; hz_rs2 = 5'd3;
        @(negedge clk);
        iss_valid = 1; iss_regwrite = 1; iss_rd = 5'd3;
        @(negedge clk); #1;                        // count 1
        checks++; if (hz_stall !== 1'b1) begin errors++; $display("FAIL sb_stall_cnt1: got %b exp 1", hz_stall); end
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL sb_full_cnt1: got %b exp 0", sb_full); end
        @(negedge clk);                            // count 2
        @(negedge clk); #1;                        // count 3
        checks++; if (sb_full !== 1'b1) begin errors++; $display("FAIL sb_full_cnt3: got %b exp 1", sb_full); end
        @(negedge clk); #1;                        // blocked issue, still 3
        checks++; if (sb_full !== 1'b1) begin errors++; $display("FAIL sb_full_saturated: got %b exp 1", sb_full); end
        iss_valid = 0;
        push_mem(5'd3, 1'b0, 3'b000, 3'd0, 64'h33, 64'h0);
        #1;
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL sb_full_no_issue: got %b exp 0", sb_full); end
        @(negedge clk); #1;                        // WB retiring rd3, count 3
        checks++; if (rf_regwrite !== 1'b1) begin errors++; $display("FAIL sb_retire1: got %b exp 1", rf_regwrite); end
        checks++; if (hz_stall !== 1'b1) begin errors++; $display("FAIL sb_stall_cnt3_ret: got %b exp 1", hz_stall); end
        @(negedge clk);                            // count 2, WB retires rd3 again
        mem_valid = 0;
        iss_valid = 1; iss_regwrite = 1; iss_rd = 5'd3;
        #1;
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL sb_full_cnt2: got %b exp 0", sb_full); end
        @(negedge clk); #1;                        // issue+retire: count stays 2
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL sb_same_cycle_unchanged: got %b exp 0", sb_full); end
        @(negedge clk); #1;                        // count 3
        checks++; if (sb_full !== 1'b1) begin errors++; $display("FAIL sb_full_again: got %b exp 1", sb_full); end
        iss_valid = 0;
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        iss_valid = 1; iss_regwrite = 1; iss_rd = 5'd0;
        hz_rs1 = 5'd0; hz_rs2 = 5'd0; rf_readdata1 = 64'h1111;
        push_mem(5'd0, 1'b0, 3'b000, 3'd0, 64'hDEAD, 64'h0);
        #1;
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL x0_sb_full: got %b exp 0", sb_full); end
        @(negedge clk);
        idle(); #1;
        checks++; if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite: got %b exp 0", rf_regwrite); end
        checks++; if (byp_data1 !== 64'h1111) begin errors++; $display("FAIL x0_byp_data1: got %h exp 1111", byp_data1); end
        checks++; if (hz_stall !== 1'b0) begin errors++; $display("FAIL x0_hz_stall: got %b exp 0", hz_stall); end
    endtask

    task automatic test_ld_err();
        @(negedge clk);
        push_mem(5'd12, 1'b1, 3'b000, 3'd0, 64'hBAD, c_ld_pat);
        @(negedge clk);
        idle(); #1;
        checks++; if (ld_err !== 1'b1) begin errors++; $display("FAIL ld_err_set: got %b exp 1", ld_err); end
        checks++; if (rf_writedata !== 64'd0) begin errors++; $display("FAIL ld_err_data: got %h exp 0", rf_writedata); end
        @(negedge clk); #1;
        checks++; if (ld_err !== 1'b0) begin errors++; $display("FAIL ld_err_one_cycle: got %b exp 0", ld_err); end
    endtask

    initial begin
        test_reset();
        test_load_extend();
        do_reset();
        test_bypass_stall();
        do_reset();
        test_scoreboard_full();
        do_reset();
        test_x0_write();
        test_ld_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rf_writeback_unit
`default_nettype wire

// File: doc/rf_writeback_unit.md
# rf_writeback_unit

Write-side initiator for the 32×64-bit register file in the multi-cycle pipelined RISC-V core. Captures MEM-stage results into a MEM/WB register, sign/zero-extends load data by funct3 and byte offset, and drives the register file's synchronous write port. Also keeps a per-register pending-write scoreboard for issue-side hazard stalls and bypasses the in-flight WB value onto the combinational read ports.

## Interface
- `NREG`, 32, architectural register count; x0 hardwired zero
- `XLEN`, 64, datapath width
- `PCNT_W`, 2, pending-write counter width per register (max 3 in flight)

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `mem_valid` in 1 — MEM stage holds a retiring instruction
- `mem_regwrite` in 1 — instruction writes rd
- `mem_memtoreg` in 1 — 1 = load data, 0 = ALU result
- `mem_rd` in 5 — destination register
- `mem_funct3` in 3 — load width code (LD 011, LW 010, LWU 110, LH 001, LHU 101)
- `mem_addr_lo` in 3 — load byte offset within doubleword
- `mem_alu_result` in 64 — ALU result
- `mem_load_data` in 64 — aligned doubleword from data memory
- `iss_valid` in 1 — instruction issuing this cycle
- `iss_regwrite` in 1 — issuing instruction writes rd
- `iss_rd` in 5 — issuing rd
- `hz_rs1`, `hz_rs2` in 5 — source registers being checked
- `rf_readdata1`, `rf_readdata2` in 64 — raw register-file read data
- `rf_regwrite` out 1 — register-file write enable
- `rf_writereg` out 5 — register-file write address
- `rf_writedata` out 64 — register-file write data
- `byp_data1`, `byp_data2` out 64 — read data with WB bypass applied
- `hz_stall` out 1 — a source register has an unbypassable pending write
- `sb_full` out 1 — issuing rd's counter is saturated; issue must stall
- `ld_err` out 1 — WB holds a load with unsupported funct3 (1 cycle)

## Operation
- MEM/WB register: captures `mem_*` each edge; `wb_valid <= mem_valid`. No hold; upstream supplies bubbles via `mem_valid=0`.
- Write data: `wb_memtoreg=0` → ALU result. Otherwise by funct3: LD full 64 b; LW/LWU select word `addr_lo[2]`, sign/zero-extend; LH/LHU select halfword `addr_lo[2:1]`, sign/zero-extend. Low offset bits below access size are ignored (no misalign trap). Other funct3 → data 0, `ld_err=1`.
- `rf_regwrite = wb_valid & wb_regwrite & (wb_rd != 0)`; `rf_writereg = wb_rd`; `rf_writedata` = extended data. x0 writes are suppressed.
- Scoreboard: 2-bit counter per register, x0 fixed 0. Increment on `iss_valid & iss_regwrite & iss_rd!=0 & !sb_full`; decrement on `rf_regwrite` for `wb_rd`. Both on same rd in one cycle → unchanged. Decrement at 0 ignored.
- `sb_full = iss_valid & iss_regwrite & cnt[iss_rd]==3`.
- Bypass: `byp_dataN = (rf_regwrite & wb_rd==hz_rsN) ? rf_writedata : rf_readdataN`; rsN=0 always passes `rf_readdataN`.
- `hz_stall` = for rs1 or rs2 (nonzero): `cnt[rs] > 1`, or `cnt[rs]==1` and not retiring on `rf_regwrite` this cycle.

## Timing
- Async reset: `wb_valid=0`, all counters 0; `rf_regwrite=0`, `rf_writereg=0`, `rf_writedata=0`, `ld_err=0`, `sb_full=0`, `hz_stall=0`. Reset mid-flight discards the WB entry and all pending counts.
- Latency: MEM input at edge N → WB outputs valid after N → register file written at N+1 → raw read correct after N+1; `byp_data` correct during cycle N..N+1.
- All outputs except WB register and counters are combinational.

## Structure
- Shared package `riscv_pkg`: load funct3 codes (LD/LW/LWU/LH/LHU), store codes, opcodes, ALUOp codes, `XLEN`.
- Sub-module `wb_scoreboard`: counter array, increment/decrement, `sb_full`, `hz_stall`. Load extension stays inline.

## Test plan
- Reset asserted mid-cycle with `mem_valid=1` → all outputs 0 immediately; counters 0 after release.
- LW, data `0x8000_0001_7FFF_FFFF`, `addr_lo=4`, rd=5 → `rf_writedata=0xFFFF_FFFF_8000_0001`; LWU same → `0x0000_0000_8000_0001`; LH `addr_lo=6` → `0xFFFF_FFFF_FFFF_8000`.
- Issue rd=7, retire ALU result `0x1234` to rd=7 → `hz_stall` for rs1=7 high until WB cycle, low in WB cycle with `byp_data1=0x1234`; next cycle counter 0.
- Three issues to rd=3 without retire → fourth issue gets `sb_full=1`, counter stays 3; simultaneous issue+retire on rd=3 → counter unchanged.
- Write to rd=0 with data `0xDEAD` → `rf_regwrite=0`, `byp_data1` for rs1=0 equals `rf_readdata1`.
- Load with funct3=000 → `ld_err=1` one cycle, `rf_writedata=0`.
